// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, address-width helper and register index type for the register bank
package regfile_pkg;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NUM_REGS = 8;
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef logic [addr_w(DEF_NUM_REGS)-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with set-over-clear priority and a registered busy count
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = addr_w(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic [ADDR_W:0]     busy_count
);
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]     count_q, count_d;
  // writeback clears, reservation sets last so a new producer wins; zero reg never busy
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
    count_d = '0;
    for (int i = 0; i < NUM_REGS; i++) count_d = count_d + {{ADDR_W{1'b0}}, busy_d[i]};
  end
  // busy vector and its popcount update together
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end
  assign busy       = busy_q;
  assign busy_count = count_q;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised 2R/1W register bank with optional bypass, hardwired zero reg and busy scoreboard
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = addr_w(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              rsv_enable,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] reg_addr_1,
  input  logic [ADDR_W-1:0] reg_addr_2,
  output logic [DATA_W-1:0] reg_data_1,
  output logic [DATA_W-1:0] reg_data_2,
  output logic              busy_1,
  output logic              busy_2,
  output logic [ADDR_W:0]   busy_count
);
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [ADDR_W-1:0]   rd_addr [2];
  logic [DATA_W-1:0]   rd_data [2];
  logic                rd_busy [2];
  logic                wr_ok;
  assign wr_ok = write_enable && !((ZERO_REG != 0) && (write_addr == '0));
  // storage next state: single write port, zero reg kept at 0
  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[write_addr] = write_data;
  end
  // storage array
  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  end
  regfile_scoreboard #(.NUM_REGS(NUM_REGS), .ZERO_REG(ZERO_REG)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .clr_en    (write_enable),
    .clr_addr  (write_addr),
    .set_en    (rsv_enable),
    .set_addr  (rsv_addr),
    .busy      (busy),
    .busy_count(busy_count)
  );
  assign rd_addr[0] = reg_addr_1;
  assign rd_addr[1] = reg_addr_2;
  for (genvar i = 0; i < 2; i++) begin : g_rd
    logic zero, hit, rsv;
    assign zero       = (ZERO_REG != 0) && (rd_addr[i] == '0);
    assign hit        = (BYPASS != 0) && write_enable && (write_addr == rd_addr[i]);
    assign rsv        = rsv_enable && (rsv_addr == rd_addr[i]);
    assign rd_data[i] = zero ? '0 : hit ? write_data : regs_q[rd_addr[i]];
    assign rd_busy[i] = zero ? 1'b0 : (hit && !rsv) ? 1'b0 : busy[rd_addr[i]];
  end
  assign reg_data_1 = rd_data[0];
  assign reg_data_2 = rd_data[1];
  assign busy_1     = rd_busy[0];
  assign busy_2     = rd_busy[1];
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed plus random checks of regfile_sb variants against a behavioural model
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst, we, re;
  logic [2:0] wa, ra, a1, a2;
  logic [7:0] wd;
  logic [2:0][7:0] d1, d2;
  logic [2:0] b1, b2;
  logic [2:0][3:0] bc;
  logic we3, re3, b13, b23;
  logic [4:0] wa3, ra3, a13, a23;
  logic [15:0] wd3, d13, d23;
  logic [5:0] bc3;
  int compared = 0, mismatched = 0;
  logic [7:0] mem [3][8];
  bit bsy [3][8];
  bit zr [3] = '{1'b1, 1'b1, 1'b0};
  bit bp [3] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  regfile_sb #(.ZERO_REG(1), .BYPASS(1)) u0 (
    .clk(clk), .rst(rst), .write_enable(we), .write_addr(wa), .write_data(wd),
    .rsv_enable(re), .rsv_addr(ra), .reg_addr_1(a1), .reg_addr_2(a2),
    .reg_data_1(d1[0]), .reg_data_2(d2[0]), .busy_1(b1[0]), .busy_2(b2[0]), .busy_count(bc[0]));
  regfile_sb #(.ZERO_REG(1), .BYPASS(0)) u1 (
    .clk(clk), .rst(rst), .write_enable(we), .write_addr(wa), .write_data(wd),
    .rsv_enable(re), .rsv_addr(ra), .reg_addr_1(a1), .reg_addr_2(a2),
    .reg_data_1(d1[1]), .reg_data_2(d2[1]), .busy_1(b1[1]), .busy_2(b2[1]), .busy_count(bc[1]));
  regfile_sb #(.ZERO_REG(0), .BYPASS(1)) u2 (
    .clk(clk), .rst(rst), .write_enable(we), .write_addr(wa), .write_data(wd),
    .rsv_enable(re), .rsv_addr(ra), .reg_addr_1(a1), .reg_addr_2(a2),
    .reg_data_1(d1[2]), .reg_data_2(d2[2]), .busy_1(b1[2]), .busy_2(b2[2]), .busy_count(bc[2]));
  regfile_sb #(.DATA_W(16), .NUM_REGS(32)) u3 (
    .clk(clk), .rst(rst), .write_enable(we3), .write_addr(wa3), .write_data(wd3),
    .rsv_enable(re3), .rsv_addr(ra3), .reg_addr_1(a13), .reg_addr_2(a23),
    .reg_data_1(d13), .reg_data_2(d23), .busy_1(b13), .busy_2(b23), .busy_count(bc3));

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ed(input int k, input logic [2:0] a);
    if (zr[k] && a == 0) return 8'h00;
    if (bp[k] && we && wa == a) return wd;
    return mem[k][a];
  endfunction

  function automatic logic eb(input int k, input logic [2:0] a);
    if (zr[k] && a == 0) return 1'b0;
    if (bp[k] && we && wa == a && !(re && ra == a)) return 1'b0;
    return bsy[k][a];
  endfunction

  function automatic int pc(input int k);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(bsy[k][i]);
    return n;
  endfunction

  task automatic check(input string tag);
    for (int k = 0; k < 3; k++) begin
      cmp($sformatf("%s.d1[%0d]", tag, k), 32'(d1[k]), 32'(ed(k, a1)));
      cmp($sformatf("%s.d2[%0d]", tag, k), 32'(d2[k]), 32'(ed(k, a2)));
      cmp($sformatf("%s.b1[%0d]", tag, k), 32'(b1[k]), 32'(eb(k, a1)));
      cmp($sformatf("%s.b2[%0d]", tag, k), 32'(b2[k]), 32'(eb(k, a2)));
      cmp($sformatf("%s.bc[%0d]", tag, k), 32'(bc[k]), 32'(pc(k)));
    end
  endtask

  task automatic upd();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int i = 0; i < 8; i++) begin
          mem[k][i] = 8'h00;
          bsy[k][i] = 1'b0;
        end
      end else begin
        if (we && !(zr[k] && wa == 0)) begin
          mem[k][wa] = wd;
          bsy[k][wa] = 1'b0;
        end
        if (re && !(zr[k] && ra == 0)) bsy[k][ra] = 1'b1;
      end
    end
  endtask

  task automatic cyc(input string tag);
    #1;
    check(tag);
    @(posedge clk);
    upd();
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; wa = '0; ra = '0; a1 = '0; a2 = '0; wd = '0;
    we3 = 1'b0; re3 = 1'b0; wa3 = '0; ra3 = '0; a13 = '0; a23 = '0; wd3 = '0;
    @(posedge clk);
    upd();
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a1 = 3'(i); a2 = 3'(7 - i);
      cyc("reset_rd");
      cmp("reset_d1", 32'(d1[0]), 32'h0);
      cmp("reset_bc", 32'(bc[0]), 32'h0);
    end
    we = 1'b1; wa = 3'd1; wd = 8'hAA; cyc("wr1");
    wa = 3'd2; wd = 8'hBB; cyc("wr2");
    we = 1'b0; a1 = 3'd1; a2 = 3'd2; cyc("rd12");
    cmp("rd_aa", 32'(d1[0]), 32'hAA);
    cmp("rd_bb", 32'(d2[0]), 32'hBB);
    wa = 3'd1; wd = 8'hFF; cyc("wr_dis");
    cmp("wr_dis", 32'(d1[0]), 32'hAA);
    we = 1'b1; wa = 3'd0; wd = 8'h55; re = 1'b1; ra = 3'd0; a1 = 3'd0; cyc("zero");
    we = 1'b0; re = 1'b0; #1;
    cmp("zero_d", 32'(d1[0]), 32'h0);
    cmp("zero_b", 32'(b1[0]), 32'h0);
    cmp("zero_bc", 32'(bc[0]), 32'h0);
    cmp("zero_ord", 32'(d1[2]), 32'h55);
    we = 1'b1; wa = 3'd3; wd = 8'hCC; a1 = 3'd3; #1;
    cmp("byp_pre", 32'(d1[0]), 32'hCC);
    cmp("nobyp_pre", 32'(d1[1]), 32'h00);
    cyc("byp");
    we = 1'b0; #1;
    cmp("nobyp_post", 32'(d1[1]), 32'hCC);
    re = 1'b1; ra = 3'd4; cyc("rsv4");
    ra = 3'd5; cyc("rsv5");
    re = 1'b0; a1 = 3'd4; a2 = 3'd5; #1;
    cmp("sb_cnt2", 32'(bc[0]), 32'd2);
    cmp("sb_b4", 32'(b1[0]), 32'd1);
    cmp("sb_b5", 32'(b2[0]), 32'd1);
    we = 1'b1; wa = 3'd4; wd = 8'h44; cyc("wr4");
    we = 1'b0; #1;
    cmp("sb_cnt1", 32'(bc[0]), 32'd1);
    we = 1'b1; wa = 3'd5; wd = 8'h5A; re = 1'b1; ra = 3'd5; a1 = 3'd5; cyc("wr_rsv5");
    we = 1'b0; re = 1'b0; #1;
    cmp("sb_b5_keep", 32'(b1[0]), 32'd1);
    cmp("sb_d5", 32'(d1[0]), 32'h5A);
    cmp("sb_cnt1b", 32'(bc[0]), 32'd1);
    rst = 1'b1; we = 1'b1; wa = 3'd6; wd = 8'hEE; re = 1'b1; ra = 3'd6; a1 = 3'd6; cyc("rst_mid");
    rst = 1'b0; we = 1'b0; re = 1'b0; #1;
    cmp("rst_d6", 32'(d1[0]), 32'h0);
    cmp("rst_b6", 32'(b1[0]), 32'h0);
    cmp("rst_cnt", 32'(bc[0]), 32'h0);
    cyc("post_rst");
    we3 = 1'b1; wa3 = 5'd31; wd3 = 16'hBEEF; a13 = 5'd31; #1;
    cmp("big_byp", 32'(d13), 32'hBEEF);
    @(posedge clk); #1;
    we3 = 1'b0; #1;
    cmp("big_rd", 32'(d13), 32'hBEEF);
    re3 = 1'b1; ra3 = 5'd31; a23 = 5'd31;
    @(posedge clk); #1;
    re3 = 1'b0; #1;
    cmp("big_busy", 32'(b23), 32'd1);
    cmp("big_cnt", 32'(bc3), 32'd1);
    we3 = 1'b1; wa3 = 5'd0; wd3 = 16'h1234; a13 = 5'd0;
    @(posedge clk); #1;
    we3 = 1'b0; #1;
    cmp("big_zero", 32'(d13), 32'h0);
    repeat (400) begin
      rst = ($urandom_range(0, 49) == 0);
      we = 1'($urandom); wa = 3'($urandom); wd = 8'($urandom);
      re = 1'($urandom); ra = 3'($urandom);
      a1 = 3'($urandom); a2 = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom);
      cyc("rnd");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
